register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised successor to the 8x16 register file. Depth, width and read-port count are configurable.
- Adds write-to-read bypass, a per-register scoreboard (busy bits) for a pipelined LC-3 datapath, and a sequenced bulk-clear engine.
- Sits between decode (reserve/read) and writeback (write/release).

Parameters:
DATA_WIDTH, 16, bits per register
ADDR_WIDTH, 3, register address bits; DEPTH = 2**ADDR_WIDTH
READ_PORTS, 2, number of independent read ports (1..4)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low; clears all state
write_en  input  1  write request
write_addr  input  ADDR_WIDTH  write target
write_data  input  DATA_WIDTH  write value
write_release  input  1  with write_en: clear busy bit of write_addr
reserve_en  input  1  mark reserve_addr busy
reserve_addr  input  ADDR_WIDTH  register to reserve
reserve_ready  output  1  busy[reserve_addr]==0 and engine idle (combinational)
read_addr  input  READ_PORTS*ADDR_WIDTH  packed read addresses, port k at [k*AW +: AW]
read_data  output  READ_PORTS*DATA_WIDTH  packed read data
read_busy  output  READ_PORTS  busy bit per read port (after same-cycle release)
clear_start  input  1  start bulk clear
clear_active  output  1  engine sweeping
clear_done  output  1  one-cycle pulse at end of sweep

Behaviour:
- Reset (reset==0, asynchronous): all registers 0, all busy bits 0, FSM IDLE, index 0. Outputs: clear_active=0, clear_done=0, read_data=0, read_busy=0.
- Write: when write_en=1 in IDLE, the register updates at the rising edge. Zero-cycle read latency: reads are combinational.
- Bypass: in IDLE, if write_en and read_addr[k]==write_addr, then read_data[k]=write_data in the same cycle. If write_release is also set, read_busy[k]=0 in that cycle.
- Reserve: reserve_en and reserve_ready sets busy[reserve_addr] at the edge. reserve_en while not ready is ignored; no state change.
- Release: write_en and write_release clears busy[write_addr] at the edge. write_en without release leaves busy unchanged.
- Simultaneous reserve and release, same address: the register is busy after the edge, because reservation wins. reserve_ready for that cycle reflects the pre-release busy bit.
- Writes to a non-busy register are legal; data is updated.
- FSM IDLE -> CLEAR on clear_start=1.
- CLEAR, each cycle:
  - reg[index]=0 and busy[index]=0; index increments.
  - When index==DEPTH-1, the next state is DONE and index wraps to 0.
  - Sweep takes exactly DEPTH cycles.
- DONE lasts one cycle: clear_done=1, then IDLE.
- clear_active=1 in CLEAR and DONE.
- While clear_active:
  - write_en, reserve_en and clear_start are ignored.
  - reserve_ready=0.
  - Bypass is disabled; reads return current stored contents, so registers not yet swept keep their old values.
- clear_start in IDLE together with write_en: the clear wins and the write is dropped.
- Reset asserted mid-sweep: immediate return to the reset state. clear_done is not pulsed.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults and FSM state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2).
- One sub-module, regfile_read_port: one address in; storage array, write bus and busy vector in; bypassed data and busy out.
- Instantiated READ_PORTS times via generate.

Test Plan:
1. Reset then read all 8 addresses on both ports -> read_data=0x0000 and read_busy=0 for all addresses.
2. Write R3=0xBEEF with read_addr port0=3 in the same cycle -> port0=0xBEEF that cycle (bypass). Next cycle, with no write -> port0 still 0xBEEF.
3. reserve R5. Next cycle: reserve_ready for addr 5 is 0, read_busy for R5 is 1, and a second reserve of R5 is ignored. Then write R5=0x1234 with release -> that cycle read_busy=0 and data=0x1234; after the edge busy=0.
4. With R2 busy, reserve R2 and write-release R2 in the same cycle -> R2 busy after the edge and data updated.
5. Load R0..R7 with 0x1111*i, reserve R6, pulse clear_start:
   - clear_active=1 for 9 cycles (8 CLEAR + 1 DONE).
   - A write to R7 in cycle 2 is dropped.
   - clear_done pulses once.
   - Afterwards all registers read 0, all busy=0, reserve_ready=1.
6. Assert reset (low) at sweep cycle 4 -> immediate clear_active=0, all registers 0, no clear_done pulse. Repeat with READ_PORTS=3, DATA_WIDTH=32, ADDR_WIDTH=4 -> identical behaviour with a 16-cycle sweep.

Source files
------------

// File: rtl/register_file_sb_pkg.sv
// Shared defaults and sweep-engine state encoding for register_file_sb.
package register_file_sb_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_READ_PORTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port with write-to-read bypass and busy lookup.
module regfile_read_port
  import register_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]                      read_addr,
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
  input  logic [(2**ADDR_WIDTH)-1:0]                 busy_vec,
  input  logic                                       bypass_en,
  input  logic [ADDR_WIDTH-1:0]                      write_addr,
  input  logic [DATA_WIDTH-1:0]                      write_data,
  input  logic                                       write_release,
  output logic [DATA_WIDTH-1:0]                      data,
  output logic                                       busy
);

  // Stored value, overridden by an accepted same-cycle write to this address.
  always_comb begin
    data = regs[read_addr];
    busy = busy_vec[read_addr];
    if (bypass_en && (read_addr == write_addr)) begin
      data = write_data;
      if (write_release) busy = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file with bypass, busy scoreboard and bulk-clear sweep.
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = DEF_READ_PORTS
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             write_en,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             write_release,
  input  logic                             reserve_en,
  input  logic [ADDR_WIDTH-1:0]            reserve_addr,
  output logic                             reserve_ready,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_busy,
  input  logic                             clear_start,
  output logic                             clear_active,
  output logic                             clear_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                 busy;
  sweep_state_t                     state, next_state;
  logic [ADDR_WIDTH-1:0]            idx, next_idx;

  logic idle, wr_ok, rel_ok, rsv_ok;

  // Qualify the decode/writeback requests against the engine state.
  always_comb begin
    idle          = (state == ST_IDLE);
    wr_ok         = idle && write_en && !clear_start;
    rel_ok        = wr_ok && write_release;
    reserve_ready = idle && !busy[reserve_addr];
    // A reserve colliding with a release of the same register is accepted even
    // though reserve_ready still shows the pre-release busy bit.
    rsv_ok        = idle && reserve_en &&
                    (!busy[reserve_addr] || (rel_ok && (write_addr == reserve_addr)));
    clear_active  = !idle;
    clear_done    = (state == ST_DONE);
  end

  // Sweep engine next-state and index sequencing.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    unique case (state)
      ST_IDLE: begin
        next_idx = '0;
        if (clear_start) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        next_idx = idx + 1'b1;
        if (idx == ADDR_WIDTH'(DEPTH - 1)) begin
          next_state = ST_DONE;
          next_idx   = '0;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Sweep engine state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  // Storage and scoreboard; in IDLE a reserve is applied after a release so it wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs <= '0;
      busy <= '0;
    end else if (state == ST_CLEAR) begin
      regs[idx] <= '0;
      busy[idx] <= 1'b0;
    end else if (idle) begin
      if (wr_ok)  regs[write_addr]   <= write_data;
      if (rel_ok) busy[write_addr]   <= 1'b0;
      if (rsv_ok) busy[reserve_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    regfile_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port (
      .read_addr    (read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .regs         (regs),
      .busy_vec     (busy),
      .bypass_en    (wr_ok),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .write_release(write_release),
      .data         (read_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .busy         (read_busy[k])
    );
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb (default and wide configs).
module tb_register_file_sb;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Instance A: 16-bit, 8 entries, 2 ports
  logic        we_a = 0, rel_a = 0, rsv_a = 0, cs_a = 0;
  logic [2:0]  wa_a = 0, rsa_a = 0;
  logic [15:0] wd_a = 0;
  logic [5:0]  ra_a = 0;
  logic [31:0] rd_a;
  logic [1:0]  rb_a;
  logic        rr_a, act_a, dn_a;

  // Instance B: 32-bit, 16 entries, 3 ports
  logic        we_b = 0, rel_b = 0, rsv_b = 0, cs_b = 0;
  logic [3:0]  wa_b = 0, rsa_b = 0;
  logic [31:0] wd_b = 0;
  logic [11:0] ra_b = 0;
  logic [95:0] rd_b;
  logic [2:0]  rb_b;
  logic        rr_b, act_b, dn_b;

  register_file_sb dut_a (
    .clock(clock), .reset(reset),
    .write_en(we_a), .write_addr(wa_a), .write_data(wd_a), .write_release(rel_a),
    .reserve_en(rsv_a), .reserve_addr(rsa_a), .reserve_ready(rr_a),
    .read_addr(ra_a), .read_data(rd_a), .read_busy(rb_a),
    .clear_start(cs_a), .clear_active(act_a), .clear_done(dn_a)
  );

  register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_PORTS(3)) dut_b (
    .clock(clock), .reset(reset),
    .write_en(we_b), .write_addr(wa_b), .write_data(wd_b), .write_release(rel_b),
    .reserve_en(rsv_b), .reserve_addr(rsa_b), .reserve_ready(rr_b),
    .read_addr(ra_b), .read_data(rd_b), .read_busy(rb_b),
    .clear_start(cs_b), .clear_active(act_b), .clear_done(dn_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    we_a = 0; rel_a = 0; rsv_a = 0; cs_a = 0;
    we_b = 0; rel_b = 0; rsv_b = 0; cs_b = 0;
  endtask

  // Counts clear_active / clear_done cycles of one instance over n cycles.
  task automatic count_sweep(input bit use_b, input int n, output int act, output int dn);
    act = 0; dn = 0;
    for (int c = 0; c < n; c++) begin
      if (use_b ? act_b : act_a) act++;
      if (use_b ? dn_b : dn_a) dn++;
      step();
    end
  endtask

  int act_n, dn_n;
  logic [2:0] a3;
  logic [3:0] a4;

  initial begin
    // 1. reset state on every address
    #2;
    for (int a = 0; a < 8; a++) begin
      a3 = 3'(a); ra_a = {a3, a3}; #1;
      chk("rst_data", rd_a, 0);
      chk("rst_busy", rb_a, 0);
    end
    chk("rst_active", act_a, 0);
    chk("rst_done", dn_a, 0);
    chk("rst_ready", rr_a, 1);
    step(); reset = 1; step();

    // 2. write R3 with same-cycle bypass, then stored read
    we_a = 1; wa_a = 3; wd_a = 16'hBEEF; ra_a = {3'd0, 3'd3}; #1;
    chk("bypass_p0", rd_a[15:0], 16'hBEEF);
    chk("bypass_p1_r0", rd_a[31:16], 16'h0000);
    step(); idle_inputs(); #1;
    chk("stored_r3", rd_a[15:0], 16'hBEEF);

    // 3. reserve R5, repeat reserve ignored, release on write
    rsv_a = 1; rsa_a = 5; #1;
    chk("rsv5_ready_pre", rr_a, 1);
    step(); rsv_a = 0; ra_a = {3'd3, 3'd5}; #1;
    chk("rsv5_ready_post", rr_a, 0);
    chk("rsv5_busy", rb_a, 2'b01);
    rsv_a = 1; step(); rsv_a = 0; #1;
    chk("rsv5_again_busy", rb_a[0], 1);
    we_a = 1; wa_a = 5; wd_a = 16'h1234; rel_a = 1; #1;
    chk("rel5_busy_same", rb_a[0], 0);
    chk("rel5_data_same", rd_a[15:0], 16'h1234);
    step(); idle_inputs(); #1;
    chk("rel5_busy_after", rb_a[0], 0);
    chk("rel5_data_after", rd_a[15:0], 16'h1234);
    chk("rel5_ready", rr_a, 1);

    // 4. R2 busy, simultaneous reserve and release: reservation wins
    rsv_a = 1; rsa_a = 2; step();
    we_a = 1; wa_a = 2; wd_a = 16'h2222; rel_a = 1; rsv_a = 1; rsa_a = 2; #1;
    chk("coll_ready", rr_a, 0);
    step(); idle_inputs(); ra_a = {3'd2, 3'd2}; #1;
    chk("coll_busy", rb_a, 2'b11);
    chk("coll_data", rd_a, {16'h2222, 16'h2222});

    // 5. load R0..R7, reserve R6, full sweep with dropped write
    for (int a = 0; a < 8; a++) begin
      we_a = 1; wa_a = 3'(a); wd_a = 16'(16'h1111 * a); step();
    end
    we_a = 0; rsv_a = 1; rsa_a = 6; step();
    rsv_a = 0; ra_a = {3'd7, 3'd6}; #1;
    chk("pre_sweep_r6", rd_a[15:0], 16'h6666);
    chk("pre_sweep_busy6", rb_a[0], 1);
    cs_a = 1; step(); cs_a = 0;
    act_n = 0; dn_n = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        we_a = 1; wa_a = 7; wd_a = 16'hFFFF; rsv_a = 1; rsa_a = 0; #1;
        chk("sweep_no_bypass_r7", rd_a[31:16], 16'h7777);
        chk("sweep_ready", rr_a, 0);
      end
      if (act_a) act_n++;
      if (dn_a) begin
        dn_n++;
        chk("done_cycle", c, 9);
      end
      step(); idle_inputs();
    end
    chk("sweep_active_cycles", act_n, 9);
    chk("sweep_done_pulses", dn_n, 1);
    for (int a = 0; a < 8; a++) begin
      a3 = 3'(a); ra_a = {a3, a3}; rsa_a = a3; #1;
      chk("post_sweep_data", rd_a, 0);
      chk("post_sweep_busy", rb_a, 0);
      chk("post_sweep_ready", rr_a, 1);
    end

    // 6a. reset during sweep cycle 4 on the default instance
    we_a = 1; wa_a = 7; wd_a = 16'h7777; step();
    we_a = 1; wa_a = 1; wd_a = 16'hAAAA; step();
    we_a = 0; cs_a = 1; step(); cs_a = 0;
    step(); step(); step();
    chk("midreset_a_active_pre", act_a, 1);
    reset = 0; #1;
    chk("midreset_a_active", act_a, 0);
    chk("midreset_a_done", dn_a, 0);
    for (int a = 0; a < 8; a++) begin
      a3 = 3'(a); ra_a = {a3, a3}; #1;
      chk("midreset_a_data", rd_a, 0);
    end
    step(); reset = 1;
    count_sweep(0, 20, act_n, dn_n);
    chk("midreset_a_no_done", dn_n, 0);
    chk("midreset_a_stay_idle", act_n, 0);

    // 6b. wide instance: bypass on port 2, full 16-cycle sweep, mid-sweep reset
    we_b = 1; wa_b = 9; wd_b = 32'hDEADBEEF; ra_b = {4'd9, 4'd0, 4'd0}; #1;
    chk("b_bypass_p2", rd_b[95:64], 32'hDEADBEEF);
    step();
    wa_b = 15; wd_b = 32'h0F0F0F0F; rsv_b = 1; rsa_b = 4; step(); idle_inputs();
    ra_b = {4'd9, 4'd15, 4'd4}; #1;
    chk("b_stored", rd_b, {32'hDEADBEEF, 32'h0F0F0F0F, 32'h0});
    chk("b_busy", rb_b, 3'b001);
    cs_b = 1; step(); cs_b = 0;
    count_sweep(1, 20, act_n, dn_n);
    chk("b_sweep_active_cycles", act_n, 17);
    chk("b_sweep_done_pulses", dn_n, 1);
    for (int a = 0; a < 16; a++) begin
      a4 = 4'(a); ra_b = {a4, a4, a4}; rsa_b = a4; #1;
      chk("b_post_data", rd_b, 0);
      chk("b_post_busy", rb_b, 0);
      chk("b_post_ready", rr_b, 1);
    end
    we_b = 1; wa_b = 15; wd_b = 32'h12345678; step();
    we_b = 0; cs_b = 1; step(); cs_b = 0;
    step(); step(); step();
    ra_b = {4'd15, 4'd15, 4'd15}; #1;
    chk("b_unswept_r15", rd_b[31:0], 32'h12345678);
    reset = 0; #1;
    chk("midreset_b_active", act_b, 0);
    chk("midreset_b_done", dn_b, 0);
    chk("midreset_b_r15", rd_b, 0);
    step(); reset = 1;
    count_sweep(1, 24, act_n, dn_n);
    chk("midreset_b_no_done", dn_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
